task5_crack_top: RTL and testbench
==================================

# task5_crack_top

Board-level top for the two-engine ARC4 key cracker on the DE1-SoC. It owns the ciphertext ROM, starts the existing `doublecrack` engine once after reset, and waits for it to finish. It then shows the recovered 24-bit key on HEX5..HEX0, or dashes if no key was found. No other logic sits above it: its ports are FPGA pins.

## Interface
- Parameters: none. Constants come from the shared package.
- `CLOCK_50`  in  1  – system clock; the only clock.
- `KEY`  in  4  – `KEY[3]` is reset: synchronous, active-high (`KEY[3]=1` resets). `KEY[2:0]` unused.
- `SW`  in  10  – unused.
- `HEX0`..`HEX5`  out  7 each  – active-low seven-segment outputs, bit order gfedcba. HEX5 shows the most significant nibble.
- `LEDR`  out  10  – status LEDs:
  - `LEDR[0]` = done.
  - `LEDR[1]` = key found.
  - `LEDR[9:2]` = 0.

## Operation
- Internal signal `key[23:0]` is the registered result, kept visible for benches.
- FSM `state`, with named states `ENABLE`, `OFF`, `DONE`:
  - Reset forces `ENABLE`; `key`=0, `found`=0, `done`=0.
  - `ENABLE`: drive `en = dc_rdy`. If `dc_rdy`=1, go to `OFF`; otherwise stay.
  - `OFF`: `en`=0. When `dc_rdy` returns to 1, latch `key <= dc_key` and `found <= dc_key_valid`, set `done`=1, and go to `DONE`.
  - `DONE`: hold until reset. `en` is never asserted again.
- `doublecrack` instance `dc`:
  - Ports: `clk`, `rst_n` (= ~KEY[3]), `en`, `rdy`, `key[23:0]`, `key_valid`, `ct_addr[7:0]`, `ct_rddata[7:0]`.
  - Contract: `rdy`=1 while idle. Accepts a start on a cycle with `en`=1 and `rdy`=1. Holds `rdy`=0 until both crack engines have finished, then raises `rdy` with `key`/`key_valid` stable.
- `ct_mem` instance `ct`:
  - 256x8 single-port ROM, contents initialised from the ciphertext image.
  - Byte 0 holds the message length; bytes 1..len hold ciphertext.
  - Read latency 1 cycle (registered address).
  - Addressed solely by `dc.ct_addr`.
- Display, per digit:
  - Before `done`: all HEX = `BLANK`.
  - `done` and `found`: HEXn = hex digit of `key[4n+3:4n]`.
  - `done` and not `found`: all HEX = `DASH`.
- Reset mid-search: FSM returns to `ENABLE` and `dc` is reset through `rst_n` the same cycle. The display blanks on the next edge. The search restarts on the first cycle after release.

## Timing
- Cycle 0 after reset release: state=`ENABLE`, `en`=1 (`dc` idle). Cycle 1: state=`OFF`.
- Latch of the result happens on the first edge where `rdy`=1 in `OFF`. HEX and LEDR update one cycle later, because the outputs are registered.
- All outputs are registered. Reset values: HEX* = 7'b1111111, LEDR = 0.
- Total runtime is set by `dc`: up to 2^23 key trials per engine.

## Structure
- Package `task5_pkg` holds:
  - Seven-segment codes: `BLANK`=1111111, digits 0–9, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110, `DASH`=0111111.
  - The FSM state enum.
- One natural sub-module: `hex7seg`. It is combinational, maps a 4-bit nibble to a 7-bit code, and is instantiated 6×.
- `doublecrack` and `ct_mem` are existing blocks and are instantiated as-is.

## Test plan
- Reset held 1 cycle with `KEY[3]`=1 → state=`ENABLE`, HEX*=1111111, LEDR=0. Release → next cycle state=`OFF`, `dc.state` leaves `IDLE`.
- Ciphertext encrypted with key 0x000018 → on `dc.rdy`, `key`=24'h000018. One cycle later HEX5..HEX2=1000000, HEX1=1111001, HEX0=0000000, LEDR[1:0]=2'b11.
- Stub `dc` returning `key_valid`=0 with `key`=0xABCDEF → all HEX=0111111, LEDR[1:0]=2'b01.
- Stub key 0xFEDCBA → HEX5..HEX0 = F,E,D,C,B,A codes (checks digit ordering and A–F decode).
- Reset asserted while in `OFF` mid-search → `dc` returns to idle, HEX blank, `en` pulses once after release, and the correct key still appears.
- Stub `dc` with `rdy`=0 for 5 cycles after reset → FSM stays in `ENABLE` with `en`=0, then pulses `en` exactly once when `rdy` rises.

Source files
------------

// File: rtl/task5_pkg.sv
// Shared constants for the ARC4 key cracker: FSM encodings, seven-segment codes
// and the ciphertext image held in the on-chip ROM.
package task5_pkg;

  typedef enum logic [1:0] {ENABLE, OFF, DONE} state_t;
  typedef enum logic [1:0] {IDLE, LOAD, SEARCH} dc_state_t;
  typedef enum logic [1:0] {E_IDLE, E_KSA, E_PRGA, E_END} eng_state_t;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  // Active-low gfedcba codes, index = nibble value.
  localparam logic [15:0][6:0] SEG_CODES = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  localparam int          PT_LEN  = 16;
  localparam logic [23:0] CT_KEY  = 24'h000018;
  localparam logic [8*PT_LEN-1:0] PT_TEXT = "Hello ARC4 world";

  function automatic logic [7:0] key_byte(input logic [23:0] k, input int n);
    case (n)
      0:       return k[23:16];
      1:       return k[15:8];
      default: return k[7:0];
    endcase
  endfunction

  // ROM image: byte 0 = length, bytes 1..len = plaintext encrypted under CT_KEY.
  function automatic logic [255:0][7:0] ct_image();
    logic [255:0][7:0] s;
    logic [255:0][7:0] img;
    logic [7:0] i, j, t, tmp;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      j = j + s[n] + key_byte(CT_KEY, n % 3);
      tmp = s[n]; s[n] = s[j]; s[j] = tmp;
    end
    img = '0;
    img[0] = 8'(PT_LEN);
    i = 8'd0;
    j = 8'd0;
    for (int n = 1; n <= PT_LEN; n++) begin
      i = i + 8'd1;
      j = j + s[i];
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      t = s[i] + s[j];
      img[n] = s[t] ^ PT_TEXT[(PT_LEN-n)*8 +: 8];
    end
    return img;
  endfunction

endpackage

// File: rtl/crack_engine.sv
// One ARC4 search engine: tries keys START, START+2, ... until the decrypted
// message is entirely printable ASCII, or the key space is exhausted, or stopped.
import task5_pkg::*;

module crack_engine #(
  parameter logic [23:0] START = 24'd0
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  len,
  output logic [7:0]  ct_idx,
  input  logic [7:0]  ct_byte,
  output logic        done,
  output logic        found,
  output logic [23:0] key
);
  eng_state_t state, state_next;
  logic [7:0] s [256];
  logic [7:0] i, j, n;
  logic [1:0] kidx;
  logic [7:0] kb, ksa_j, i1, j1, si, sj, t, pad, pt;
  logic       pt_ok, last_key;

  always_comb begin
    case (kidx)
      2'd0:    kb = key[23:16];
      2'd1:    kb = key[15:8];
      default: kb = key[7:0];
    endcase
  end

  assign ksa_j = j + s[i] + kb;
  assign i1    = i + 8'd1;
  assign si    = s[i1];
  assign j1    = j + si;
  assign sj    = s[j1];
  assign t     = si + sj;
  // Keystream byte is read from the post-swap array, so patch the two swapped slots.
  assign pad   = (t == i1) ? sj : (t == j1) ? si : s[t];
  assign ct_idx = n;
  assign pt    = ct_byte ^ pad;
  assign pt_ok = (pt >= 8'h20) && (pt <= 8'h7e);
  assign last_key = (key >= 24'hfffffe);
  assign done  = (state == E_END);

  always_comb begin
    state_next = state;
    case (state)
      E_IDLE, E_END: if (start) state_next = E_KSA;
      E_KSA: begin
        if (stop)              state_next = E_END;
        else if (i == 8'hff)   state_next = E_PRGA;
      end
      E_PRGA: begin
        if (stop)              state_next = E_END;
        else if (!pt_ok)       state_next = last_key ? E_END : E_KSA;
        else if (n == len)     state_next = E_END;
      end
      default: state_next = E_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state <= E_IDLE;
      found <= 1'b0;
      key   <= START;
      i     <= 8'd0;
      j     <= 8'd0;
      n     <= 8'd0;
      kidx  <= 2'd0;
    end else begin
      state <= state_next;
      case (state)
        E_IDLE, E_END: if (start) begin
          key   <= START;
          found <= 1'b0;
          i     <= 8'd0;
          j     <= 8'd0;
          kidx  <= 2'd0;
          for (int x = 0; x < 256; x++) s[x] <= 8'(x);
        end
        E_KSA: begin
          s[i]     <= s[ksa_j];
          s[ksa_j] <= s[i];
          j        <= ksa_j;
          i        <= i + 8'd1;
          kidx     <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
          if (i == 8'hff) begin
            j <= 8'd0;
            n <= 8'd1;
          end
        end
        E_PRGA: if (!stop) begin
          s[i1] <= sj;
          s[j1] <= si;
          i     <= i1;
          j     <= j1;
          n     <= n + 8'd1;
          if (!pt_ok) begin
            if (!last_key) begin
              key  <= key + 24'd2;
              i    <= 8'd0;
              j    <= 8'd0;
              kidx <= 2'd0;
              for (int x = 0; x < 256; x++) s[x] <= 8'(x);
            end
          end else if (n == len) begin
            found <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ct_mem.sv
// 256x8 ciphertext ROM with registered read.
import task5_pkg::*;

module ct_mem (
  input  logic       clk,
  input  logic [7:0] addr,
  output logic [7:0] rddata
);
  localparam logic [255:0][7:0] IMAGE = ct_image();

  always_ff @(posedge clk) rddata <= IMAGE[addr];
endmodule

// File: rtl/doublecrack.sv
// Two-engine cracker: copies the ciphertext locally, then runs even/odd key
// engines in parallel; whichever finds a key stops the other.
import task5_pkg::*;

module doublecrack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic [23:0] key,
  output logic        key_valid,
  output logic [7:0]  ct_addr,
  input  logic [7:0]  ct_rddata
);
  dc_state_t   state, state_next;
  logic        srst, start;
  logic [8:0]  load_cnt;
  logic [7:0]  ct_copy [256];
  logic [1:0]  eng_done, eng_found;
  logic [7:0]  eng_idx  [2];
  logic [7:0]  eng_byte [2];
  logic [23:0] eng_key  [2];

  assign srst    = ~rst_n;
  assign rdy     = (state == IDLE);
  assign ct_addr = load_cnt[7:0];
  assign start   = (state == LOAD) && (load_cnt == 9'd256);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_eng
      assign eng_byte[gi] = ct_copy[eng_idx[gi]];
      crack_engine #(.START(24'(gi))) u_eng (
        .clk     (clk),
        .srst    (srst),
        .start   (start),
        .stop    (eng_found[1-gi]),
        .len     (ct_copy[0]),
        .ct_idx  (eng_idx[gi]),
        .ct_byte (eng_byte[gi]),
        .done    (eng_done[gi]),
        .found   (eng_found[gi]),
        .key     (eng_key[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = LOAD;
      LOAD:    if (load_cnt == 9'd256) state_next = SEARCH;
      SEARCH:  if (&eng_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= IDLE;
      load_cnt  <= 9'd0;
      key       <= 24'd0;
      key_valid <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: load_cnt <= 9'd0;
        LOAD: begin
          // ROM data lags the address by one cycle.
          load_cnt <= load_cnt + 9'd1;
          if (load_cnt != 9'd0) ct_copy[load_cnt[7:0] - 8'd1] <= ct_rddata;
        end
        SEARCH: if (&eng_done) begin
          key       <= eng_found[0] ? eng_key[0] : eng_key[1];
          key_valid <= |eng_found;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/hex7seg.sv
// Nibble to active-low seven-segment code.
import task5_pkg::*;

module hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_CODES[nibble];
endmodule

// File: rtl/task5_crack_top.sv
// DE1-SoC top: starts doublecrack once after reset and shows the recovered key
// on HEX5..HEX0 (dashes if none found).
import task5_pkg::*;

module task5_crack_top (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);
  logic            clk, srst, unused_pins;
  state_t          state, state_next;
  logic            en, dc_rdy, dc_key_valid;
  logic [23:0]     dc_key, key;
  logic [7:0]      ct_addr, ct_rddata;
  logic            found, done;
  logic [5:0][6:0] digit, hex_next, hex;

  assign clk         = CLOCK_50;
  assign srst        = KEY[3];
  assign unused_pins = ^{SW, KEY[2:0]};

  doublecrack dc (
    .clk       (clk),
    .rst_n     (~KEY[3]),
    .en        (en),
    .rdy       (dc_rdy),
    .key       (dc_key),
    .key_valid (dc_key_valid),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata)
  );

  ct_mem ct (
    .clk    (clk),
    .addr   (ct_addr),
    .rddata (ct_rddata)
  );

  always_comb begin
    state_next = state;
    en         = 1'b0;
    case (state)
      ENABLE: begin
        en = dc_rdy;
        if (dc_rdy) state_next = OFF;
      end
      OFF:     if (dc_rdy) state_next = DONE;
      DONE:    ;
      default: state_next = ENABLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state <= ENABLE;
      key   <= 24'd0;
      found <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == OFF && dc_rdy) begin
        key   <= dc_key;
        found <= dc_key_valid;
        done  <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      hex7seg u_seg (.nibble(key[4*gi +: 4]), .seg(digit[gi]));
      assign hex_next[gi] = !done ? BLANK : (found ? digit[gi] : DASH);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      hex  <= {6{BLANK}};
      LEDR <= 10'd0;
    end else begin
      hex  <= hex_next;
      LEDR <= {8'd0, found, done};
    end
  end

  assign HEX0 = hex[0];
  assign HEX1 = hex[1];
  assign HEX2 = hex[2];
  assign HEX3 = hex[3];
  assign HEX4 = hex[4];
  assign HEX5 = hex[5];
endmodule

// File: tb/tb_task5_crack_top.sv
// Bench for task5_crack_top: real search against an RC4 brute-force model,
// plus forced doublecrack responses for the not-found and digit-decode cases.
module tb_task5_crack_top;
  import task5_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  int n_cmp = 0;
  int n_err = 0;
  int exp_key;
  int ct_b [16];
  string plain = "Hello ARC4 world";
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #10 CLOCK_50 = ~CLOCK_50;

  task5_crack_top dut (
    .CLOCK_50 (CLOCK_50), .KEY (KEY), .SW (SW),
    .HEX0 (HEX0), .HEX1 (HEX1), .HEX2 (HEX2),
    .HEX3 (HEX3), .HEX4 (HEX4), .HEX5 (HEX5),
    .LEDR (LEDR)
  );

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [41:0] hex_bus();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  function automatic logic [41:0] exp_hex(input int k, input bit fnd);
    logic [41:0] r;
    for (int d = 0; d < 6; d++) r[7*d +: 7] = fnd ? seg_tab[(k >> (4*d)) & 15] : 7'b0111111;
    return r;
  endfunction

  function automatic void rc4_ks(input int k, output int ks [16]);
    int s [256];
    int i, j, t;
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + s[x] + ((k >> (8 * (2 - x % 3))) & 255)) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int n = 0; n < 16; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks[n] = s[(s[i] + s[j]) % 256];
    end
  endfunction

  // Smallest key whose decryption of the message is all printable ASCII.
  task automatic build_model();
    int ks [16];
    bit ok;
    rc4_ks(24'h000018, ks);
    for (int n = 0; n < 16; n++) ct_b[n] = int'(plain[n]) ^ ks[n];
    exp_key = -1;
    for (int k = 0; k < 4096 && exp_key < 0; k++) begin
      rc4_ks(k, ks);
      ok = 1'b1;
      for (int n = 0; n < 16; n++)
        if (((ct_b[n] ^ ks[n]) < 32) || ((ct_b[n] ^ ks[n]) > 126)) ok = 1'b0;
      if (ok) exp_key = k;
    end
    $display("model: expected key %06h", exp_key);
  endtask

  task automatic test_reset();
    KEY = 4'b1000;
    SW  = 10'd0;
    step();
    n_cmp++;
    if (dut.state !== ENABLE) begin n_err++; $display("FAIL reset_state: got %0d want ENABLE", dut.state); end
    n_cmp++;
    if (hex_bus() !== {6{7'b1111111}}) begin n_err++; $display("FAIL reset_hex: got %h want all 1111111", hex_bus()); end
    n_cmp++;
    if (LEDR !== 10'd0) begin n_err++; $display("FAIL reset_ledr: got %b want 0", LEDR); end
    KEY[3] = 1'b0;
    n_cmp++;
    if (dut.en !== 1'b1) begin n_err++; $display("FAIL release_en: got %b want 1", dut.en); end
    step();
    n_cmp++;
    if (dut.state !== OFF) begin n_err++; $display("FAIL cycle1_state: got %0d want OFF", dut.state); end
    n_cmp++;
    if (dut.dc.state === IDLE) begin n_err++; $display("FAIL cycle1_dc_state: got IDLE want not IDLE"); end
    $display("test_reset: done");
  endtask

  // Waits in OFF for dc.rdy, then checks the latch and the registered display.
  task automatic finish_search(input string tag, input int en_prior);
    int cyc = 0;
    int en_cnt = en_prior;
    while (!(dut.state == OFF && dut.dc_rdy === 1'b1) && cyc < 20000) begin
      if (dut.en) en_cnt++;
      step();
      cyc++;
    end
    n_cmp++;
    if (cyc >= 20000) begin
      n_err++; $display("FAIL %s_timeout: no rdy after %0d cycles", tag, cyc);
      return;
    end
    n_cmp++;
    if (en_cnt != 1) begin n_err++; $display("FAIL %s_en_pulses: got %0d want 1", tag, en_cnt); end
    step();
    n_cmp++;
    if (dut.key !== 24'(exp_key)) begin n_err++; $display("FAIL %s_key: got %h want %h", tag, dut.key, exp_key); end
    n_cmp++;
    if (LEDR !== 10'd0) begin n_err++; $display("FAIL %s_ledr_early: got %b want 0", tag, LEDR); end
    step();
    n_cmp++;
    if (hex_bus() !== exp_hex(exp_key, 1'b1)) begin n_err++; $display("FAIL %s_hex: got %h want %h", tag, hex_bus(), exp_hex(exp_key, 1'b1)); end
    n_cmp++;
    if (LEDR !== 10'b0000000011) begin n_err++; $display("FAIL %s_ledr: got %b want 0000000011", tag, LEDR); end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (dut.en !== 1'b0 || dut.state !== DONE) begin n_err++; $display("FAIL %s_hold: en %b state %0d want 0 DONE", tag, dut.en, dut.state); end
      step();
    end
    $display("%s: key %06h after %0d cycles", tag, dut.key, cyc);
  endtask

  task automatic test_crack();
    finish_search("crack", 1);
  endtask

  task automatic test_reset_mid_search();
    int wait_cyc;
    int en_cnt = 0;
    KEY[3] = 1'b1;
    step();
    n_cmp++;
    if (hex_bus() !== {6{7'b1111111}}) begin n_err++; $display("FAIL mid_blank: got %h want all 1111111", hex_bus()); end
    KEY[3] = 1'b0;
    wait_cyc = $urandom_range(300, 2500);
    for (int c = 0; c < wait_cyc; c++) step();
    n_cmp++;
    if (dut.state !== OFF) begin n_err++; $display("FAIL mid_searching: got %0d want OFF", dut.state); end
    KEY[3] = 1'b1;
    step();
    n_cmp++;
    if (dut.state !== ENABLE || dut.dc.state !== IDLE) begin
      n_err++; $display("FAIL mid_reset: state %0d dc %0d want ENABLE IDLE", dut.state, dut.dc.state);
    end
    KEY[3] = 1'b0;
    if (dut.en) en_cnt++;
    step();
    $display("test_reset_mid_search: reset after %0d cycles", wait_cyc);
    finish_search("mid", en_cnt);
  endtask

  task automatic test_stub(input int rdy_low, input logic [23:0] k, input bit v);
    KEY[3] = 1'b1;
    force dut.dc_rdy = 1'b0;
    force dut.dc_key = k;
    force dut.dc_key_valid = v;
    step();
    KEY[3] = 1'b0;
    for (int c = 0; c < rdy_low; c++) begin
      n_cmp++;
      if (dut.state !== ENABLE || dut.en !== 1'b0) begin n_err++; $display("FAIL stub_wait: state %0d en %b want ENABLE 0", dut.state, dut.en); end
      step();
    end
    force dut.dc_rdy = 1'b1;
    #1;
    n_cmp++;
    if (dut.en !== 1'b1) begin n_err++; $display("FAIL stub_en_rise: got %b want 1", dut.en); end
    step();
    n_cmp++;
    if (dut.state !== OFF || dut.en !== 1'b0) begin n_err++; $display("FAIL stub_off: state %0d en %b want OFF 0", dut.state, dut.en); end
    force dut.dc_rdy = 1'b0;
    repeat (3) step();
    force dut.dc_rdy = 1'b1;
    step();
    n_cmp++;
    if (dut.key !== k || dut.state !== DONE) begin n_err++; $display("FAIL stub_latch: key %h state %0d want %h DONE", dut.key, dut.state, k); end
    step();
    n_cmp++;
    if (hex_bus() !== exp_hex(int'(k), v)) begin n_err++; $display("FAIL stub_hex: got %h want %h", hex_bus(), exp_hex(int'(k), v)); end
    n_cmp++;
    if (LEDR !== {8'd0, v, 1'b1}) begin n_err++; $display("FAIL stub_ledr: got %b want %b", LEDR, {8'd0, v, 1'b1}); end
    n_cmp++;
    if (dut.en !== 1'b0) begin n_err++; $display("FAIL stub_done_en: got %b want 0", dut.en); end
    release dut.dc_rdy;
    release dut.dc_key;
    release dut.dc_key_valid;
    KEY[3] = 1'b1;
    step();
    $display("test_stub: rdy_low %0d key %06h valid %0d", rdy_low, k, v);
  endtask

  initial begin
    build_model();
    test_reset();
    test_crack();
    test_reset_mid_search();
    test_stub(5, 24'($urandom), 1'b1);
    test_stub(2, 24'hABCDEF, 1'b0);
    test_stub(3, 24'hFEDCBA, 1'b1);
    for (int r = 0; r < 3; r++)
      test_stub($urandom_range(1, 8), 24'($urandom), 1'($urandom_range(0, 1)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
